// File: rtl/eth_rx_addr_filter.sv
// ---------------------------------------------------------------------------
// eth_rx_addr_filter
//
// Receive destination-address filter, in the receive byte clock domain.
// It strips the preamble and SFD, then compares the 6-byte destination
// address against a host-loaded MAC table. It also applies the broadcast,
// multicast and promiscuous rules, and emits one accept/reject decision
// per frame.
//
// Ports
//   clk        receive byte clock
//   clr        synchronous active-high reset
//   rxdv/rxer  receive data valid / receive error
//   datain     receive byte, sampled when rxdv=1
//   promis     promiscuous mode
//   mcast      accept-all-multicast mode
//   tbl_we     table write strobe (one 16-bit word per cycle)
//   tbl_idx    table entry index
//   tbl_word   word in entry: 0=bytes0/1, 1=bytes2/3, 2=bytes4/5, 3=ignored
//   tbl_data   [7:0] earlier wire byte, [15:8] later wire byte
//   tbl_clr    clear all entry-valid bits
//   tbl_busy   frame in preamble/DA; table writes are dropped
//   acc_valid  one-cycle decision strobe
//   acc        1 = accept frame (held until the next strobe)
//   hit_idx    lowest matching table index, 4'hF if none
//   why        0=reject 1=table 2=broadcast 3=multicast 4=promiscuous 5=runt/error
// ---------------------------------------------------------------------------
module eth_rx_addr_filter #(
  parameter int         NADDR = 14,
  parameter logic [7:0] SFD   = 8'hD5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rxdv,
  input  logic        rxer,
  input  logic [7:0]  datain,
  input  logic        promis,
  input  logic        mcast,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_idx,
  input  logic [1:0]  tbl_word,
  input  logic [15:0] tbl_data,
  input  logic        tbl_clr,
  output logic        tbl_busy,
  output logic        acc_valid,
  output logic        acc,
  output logic [3:0]  hit_idx,
  output logic [2:0]  why
);

  localparam logic [2:0] WHY_REJECT = 3'd0;
  localparam logic [2:0] WHY_TABLE  = 3'd1;
  localparam logic [2:0] WHY_BCAST  = 3'd2;
  localparam logic [2:0] WHY_MCAST  = 3'd3;
  localparam logic [2:0] WHY_PROMIS = 3'd4;
  localparam logic [2:0] WHY_RUNT   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DA, S_WAIT} state_t;

  state_t           state;
  logic [7:0]       ent [NADDR][6];
  logic [NADDR-1:0] valid;
  logic [NADDR-1:0] match;
  logic [NADDR-1:0] match_nx;
  logic             bcast;
  logic             bcast_nx;
  logic             mc;
  logic [2:0]       k;
  logic             tbl_ok;
  logic             hit_any;
  logic [3:0]       hit_first;

  // Decision priority for a complete destination address.
  function automatic logic [2:0] reason(input logic hit, input logic bc,
                                        input logic mcf, input logic mcen,
                                        input logic pr);
    if (hit)              return WHY_TABLE;
    else if (bc)          return WHY_BCAST;
    else if (mcf && mcen) return WHY_MCAST;
    else if (pr)          return WHY_PROMIS;
    else                  return WHY_REJECT;
  endfunction

  assign tbl_busy = (state == S_PRE) || (state == S_DA);

  // A table write lands only when idle enough, in range, not reserved,
  // and not overridden by a simultaneous clear.
  assign tbl_ok = tbl_we && !tbl_busy && !tbl_clr &&
                  (int'(tbl_idx) < NADDR) && (tbl_word != 2'd3);

  // Running per-entry comparison including the byte on the wire now, so
  // the decision can be registered on the same edge as the last DA byte.
  always_comb begin
    for (int i = 0; i < NADDR; i++) begin
      match_nx[i] = match[i] && valid[i] && (datain == ent[i][k]);
    end
    bcast_nx  = bcast && (datain == 8'hFF);
    hit_any   = 1'b0;
    hit_first = 4'hF;
    for (int i = NADDR - 1; i >= 0; i--) begin
      if (match_nx[i]) begin
        hit_any   = 1'b1;
        hit_first = 4'(i);
      end
    end
  end

  // Table byte storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (tbl_ok) begin
      ent[tbl_idx][{tbl_word, 1'b0}] <= tbl_data[7:0];
      ent[tbl_idx][{tbl_word, 1'b1}] <= tbl_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      valid     <= '0;
      acc_valid <= 1'b0;
      acc       <= 1'b0;
      hit_idx   <= 4'hF;
      why       <= WHY_REJECT;
    end else begin
      acc_valid <= 1'b0;

      if (!tbl_busy && tbl_clr) begin
        valid <= '0;
      end else begin
        for (int i = 0; i < NADDR; i++) begin
          if (tbl_ok && (int'(tbl_idx) == i)) valid[i] <= (tbl_word == 2'd2);
        end
      end

      case (state)
        // IDLE evaluates its first byte exactly as PRE would.
        S_IDLE, S_PRE: begin
          if (!rxdv) begin
            state <= S_IDLE;
          end else if (datain == SFD) begin
            state <= S_DA;
            k     <= 3'd0;
            match <= '1;
            bcast <= 1'b1;
          end else begin
            state <= S_PRE;
          end
        end

        S_DA: begin
          if (!rxdv || rxer) begin
            state     <= S_WAIT;
            acc_valid <= 1'b1;
            acc       <= 1'b0;
            hit_idx   <= 4'hF;
            why       <= WHY_RUNT;
          end else begin
            match <= match_nx;
            bcast <= bcast_nx;
            k     <= k + 3'd1;
            if (k == 3'd0) mc <= datain[0];
            if (k == 3'd5) begin
              state     <= S_WAIT;
              acc_valid <= 1'b1;
              why       <= reason(hit_any, bcast_nx, mc, mcast, promis);
              acc       <= (reason(hit_any, bcast_nx, mc, mcast, promis) != WHY_REJECT);
              hit_idx   <= hit_first;
            end
          end
        end

        S_WAIT: begin
          if (!rxdv) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_rx_addr_filter.md
Name: eth_rx_addr_filter

Overview:
- Receive destination-address filter in the e_rxc/loop-muxed receive clock domain. It sits between the receive byte stream (rxdbl/rxdvl/rxerl) and the frame-store logic of the receive path.
- Strips preamble/SFD, compares the 6-byte destination address against a host-loaded MAC table (setup-frame addresses), and applies broadcast, multicast and promiscuous rules.
- Emits a single accept/reject decision per frame, which the receive path uses to keep or discard the frame.

Parameters:
- NADDR, 14, number of MAC table entries (1..16)
- SFD, 8'hD5, start-of-frame delimiter byte value

Ports:
- clk  in  1  receive byte clock (rxclkl)
- clr  in  1  synchronous active-high reset
- rxdv  in  1  receive data valid
- rxer  in  1  receive error
- datain  in  8  receive byte, sampled on posedge clk when rxdv=1
- promis  in  1  promiscuous mode (synchronised ethmode_i[9])
- mcast  in  1  accept-all-multicast mode (synchronised ethmode_i[8])
- tbl_we  in  1  table write strobe, one word per cycle
- tbl_idx  in  4  table entry index
- tbl_word  in  2  word within entry: 0=bytes0/1, 1=bytes2/3, 2=bytes4/5; 3=reserved, write ignored
- tbl_data  in  16  [7:0] = earlier byte on the wire, [15:8] = later byte
- tbl_clr  in  1  clear all entry-valid bits
- tbl_busy  out  1  1 while a frame is in PRE or DA; writes are dropped while set
- acc_valid  out  1  one-cycle decision strobe
- acc  out  1  1 = accept frame; meaningful only with acc_valid
- hit_idx  out  4  lowest matching table index; 4'hF if none
- why  out  3  decision reason: 0=reject, 1=table, 2=broadcast, 3=multicast, 4=promiscuous, 5=runt/error

Behaviour:
- Reset (clr=1 at posedge clk):
  - state=IDLE; all entry-valid bits=0.
  - acc_valid=0, acc=0, hit_idx=4'hF, why=0, tbl_busy=0.
  - Table byte contents are not reset.
- Table:
  - A write to word 2 sets valid[tbl_idx]. Writes to words 0/1 clear valid[tbl_idx].
  - tbl_idx >= NADDR: write ignored.
  - tbl_clr takes priority over a tbl_we in the same cycle.
  - While tbl_busy=1, writes and tbl_clr are dropped silently.
- FSM states: IDLE, PRE, DA, WAIT.
  - IDLE: rxdv=1 -> PRE. The byte sampled on this edge is also evaluated as in PRE.
  - PRE: byte==SFD -> DA with byte counter k=0. Any other byte is discarded.
  - PRE: rxdv=0 -> IDLE with no decision (noise, not counted as a frame).
  - DA, one byte per rxdv=1 cycle:
    - match[i] &= valid[i] && byte==entry[i].byte[k].
    - bcast &= (byte==8'hFF).
    - On k=0, latch mc=byte[0].
    - k increments 0..5.
  - DA -> WAIT on the 6th byte (k=5). On the next cycle, acc_valid=1.
  - DA with rxdv=0 or rxer=1 before the 6th byte -> WAIT. On the next cycle, acc_valid=1, acc=0, why=5, hit_idx=4'hF.
  - WAIT: stay until rxdv=0, then -> IDLE. rxer in WAIT has no effect (reported elsewhere).
  - A new rxdv=1 arriving in the same cycle WAIT exits is not possible; at least one rxdv=0 cycle separates frames.
- Decision priority for a complete DA:
  - table hit -> acc=1, why=1, hit_idx=lowest i with match[i]
  - else broadcast -> acc=1, why=2
  - else mc & mcast -> acc=1, why=3
  - else promis -> acc=1, why=4
  - else acc=0, why=0
- acc/hit_idx/why hold their value until the next acc_valid. acc_valid is exactly 1 cycle wide.
- promis/mcast are sampled at the decision cycle, not at frame start.
- tbl_busy=1 whenever state is PRE or DA.
- clr mid-frame: immediate return to IDLE with no decision strobe. The next rxdv=1 is treated as a new frame.

Test Plan:
1. Load entry 3 = 08:00:2B:11:22:33 (tbl_data 16'h0008, 16'h112B, 16'h3322); send 7x55, D5, that DA -> acc_valid 1 cycle after byte 6, acc=1, why=1, hit_idx=3.
2. Same table; DA FF:FF:FF:FF:FF:FF -> acc=1, why=2, hit_idx=F. DA 01:00:5E:00:00:01: with mcast=0, promis=0 -> acc=0, why=0; with mcast=1 -> acc=1, why=3.
3. Unmatched unicast 02:00:00:00:00:01 with promis=1 -> acc=1, why=4. Load the same address into entries 5 and 2 -> hit_idx=2, why=1.
4. rxdv drops after 3 DA bytes -> acc_valid next cycle, acc=0, why=5. rxer pulse at DA byte 4 of a matching frame -> why=5. Preamble-only burst with no D5 -> no acc_valid.
5. tbl_we to entry 3 word 2 during DA -> dropped, tbl_busy=1, and the decision uses the old table. tbl_clr in IDLE -> a previously matching DA is rejected.
6. clr asserted at DA byte 2 -> no acc_valid, outputs at reset values. The next full frame is decided normally.
